y86_decode_regfile: RTL and testbench
=====================================

// Module: y86_decode_regfile
// PURPOSE
// Y86-64 SEQ decode/write-back block: merges register-ID decode logic with the 15-entry
// 64-bit register file. Decodes icode/rA/rB/cnd into srcA/srcB/dstE/dstM, reads valA/valB
// combinationally, and writes execute/memory results (valE/valM) back on the clock edge.
// Sits between fetch (icode, rA, rB) and execute/memory (valE, valM, cnd).
// PARAMETERS
// W      64  register/data width
// NREG   15  architectural registers (IDs 0x0-0xE); ID 0xF = RNONE, no register
// PORTS
// clk    in   1   clock, rising-edge active
// rst_n  in   1   synchronous active-low reset
// icode  in   4   instruction code
// rA     in   4   register A field
// rB     in   4   register B field
// cnd    in   1   condition flag (gates cmovXX write)
// valE   in   W   execute result, written to dstE
// valM   in   W   memory result, written to dstM
// srcA   out  4   decoded read-port A ID
// srcB   out  4   decoded read-port B ID
// dstE   out  4   decoded E write ID
// dstM   out  4   decoded M write ID
// valA   out  W   R[srcA], 0 when srcA=0xF
// valB   out  W   R[srcB], 0 when srcB=0xF
// BEHAVIOUR
// - icode: 0 halt,1 nop,2 rrmov/cmov,3 irmov,4 rmmov,5 mrmov,6 OPq,7 jXX,8 call,9 ret,A push,B pop.
// - srcA = rA for {2,4,6,A}; 4 (%rsp) for {9,B}; else 0xF.
// - srcB = rB for {4,5,6}; 4 for {8,9,A,B}; else 0xF.
// - dstE = (icode==2) ? (cnd ? rB : 0xF) : rB for {3,6}; 4 for {8,9,A,B}; else 0xF.
// - dstM = rA for {5,B}; else 0xF. Codes C-F: all IDs 0xF, no write.
// - Decode and reads purely combinational, zero latency; valA/valB track current inputs.
// - Write: on rising clk when rst_n=1: if dstE!=0xF R[dstE]<=valE; if dstM!=0xF R[dstM]<=valM.
// - dstE==dstM (popq %rsp): valM wins; R[4]=valM after edge.
// - Read of a register written this cycle returns the pre-edge value (no bypass by default).
// - Reset: rst_n=0 at rising clk clears all 15 regs to 0, suppresses writes that cycle;
//   ID outputs remain combinational from inputs; valA/valB read 0 after reset edge.
// - Reset asserted mid-sequence discards that cycle's pending write.
// CONFIGURATION
// REGFILE_BYPASS_EN defined: valA/valB forward same-cycle write data; srcX==dstM -> valM,
//   else srcX==dstE -> valE, else R[srcX] (0xF never matches).
// Undefined: plain register reads, pre-edge values only (default build).
// TESTING
// 1 Reset, then irmovq icode=3 rA=F rB=1 valE=0x420 -> srcA=srcB=dstM=F, dstE=1; R1=0x420 after edge.
// 2 irmovq icode=3 rB=4 valE=0x20 -> dstE=4; next: ret icode=9 -> srcA=srcB=4, valA=valB=0x20,
//   dstE=4; valE=0x28 -> R4=0x28 after edge.
// 3 cmovq icode=2 rA=1 rB=7 cnd=1 valE=0x420 -> srcA=1, valA=0x420, dstE=7; R7=0x420 after edge.
// 4 cmovq icode=2 rA=7 rB=6 cnd=0 -> srcA=7, valA=0x420, dstE=F; R6 stays 0.
// 5 popq icode=B rA=4, valE=0x30, valM=0x99 -> dstE=dstM=4; R4=0x99 after edge.
// 6 Load R3=0x55, then rst_n=0 one edge with icode=3 rB=3 valE=0x77 -> R3=0, all regs 0.

Source files
------------

// File: rtl/y86_decode_regfile_if.sv
// Decode/write-back bus between the fetch/execute side (master) and the
// register-file block (slave): instruction fields and write data in,
// decoded register IDs and read data out.
interface y86_decode_regfile_if #(
   parameter int W = 64
);
   logic [3:0]   icode;
   logic [3:0]   rA;
   logic [3:0]   rB;
   logic         cnd;
   logic [W-1:0] valE;
   logic [W-1:0] valM;
   logic [3:0]   srcA;
   logic [3:0]   srcB;
   logic [3:0]   dstE;
   logic [3:0]   dstM;
   logic [W-1:0] valA;
   logic [W-1:0] valB;

   modport master (
      output icode, rA, rB, cnd, valE, valM,
      input  srcA, srcB, dstE, dstM, valA, valB
   );

   modport slave (
      input  icode, rA, rB, cnd, valE, valM,
      output srcA, srcB, dstE, dstM, valA, valB
   );
endinterface

// File: rtl/y86_decode_regfile.sv
// Y86-64 SEQ decode + write-back: register-ID decode, 15x64 register file,
// combinational reads, clocked valE/valM write-back (valM wins on dstE==dstM).
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data to valA/valB.
module y86_decode_regfile #(
   parameter int W    = 64,
   parameter int NREG = 15
) (
   input logic                 clk,
   input logic                 rst_n,
   y86_decode_regfile_if.slave bus
);
   typedef enum logic [3:0] {
      I_HALT  = 4'h0,
      I_NOP   = 4'h1,
      I_RRMOV = 4'h2,
      I_IRMOV = 4'h3,
      I_RMMOV = 4'h4,
      I_MRMOV = 4'h5,
      I_OPQ   = 4'h6,
      I_JXX   = 4'h7,
      I_CALL  = 4'h8,
      I_RET   = 4'h9,
      I_PUSH  = 4'hA,
      I_POP   = 4'hB
   } icode_e;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   logic [3:0]   src_a, src_b, dst_e, dst_m;
   logic [W-1:0] val_a, val_b;
   logic [W-1:0] regs_q [NREG];
   logic [W-1:0] regs_d [NREG];

   // Register-ID decode from the instruction fields
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode_e'(bus.icode))
         I_RRMOV: begin
            src_a = bus.rA;
            dst_e = bus.cnd ? bus.rB : RNONE;
         end
         I_IRMOV: dst_e = bus.rB;
         I_RMMOV: begin
            src_a = bus.rA;
            src_b = bus.rB;
         end
         I_MRMOV: begin
            src_b = bus.rB;
            dst_m = bus.rA;
         end
         I_OPQ: begin
            src_a = bus.rA;
            src_b = bus.rB;
            dst_e = bus.rB;
         end
         I_CALL: begin
            src_b = RSP;
            dst_e = RSP;
         end
         I_RET: begin
            src_a = RSP;
            src_b = RSP;
            dst_e = RSP;
         end
         I_PUSH: begin
            src_a = bus.rA;
            src_b = RSP;
            dst_e = RSP;
         end
         I_POP: begin
            src_a = RSP;
            src_b = RSP;
            dst_e = RSP;
            dst_m = bus.rA;
         end
         default: ;
      endcase
   end

   // Read ports: RNONE reads as zero; optional same-cycle forwarding (valM first)
   always_comb begin
      val_a = '0;
      val_b = '0;
`ifdef REGFILE_BYPASS_EN
      if (src_a != RNONE) begin
         if (src_a == dst_m)      val_a = bus.valM;
         else if (src_a == dst_e) val_a = bus.valE;
         else                     val_a = regs_q[src_a];
      end
      if (src_b != RNONE) begin
         if (src_b == dst_m)      val_b = bus.valM;
         else if (src_b == dst_e) val_b = bus.valE;
         else                     val_b = regs_q[src_b];
      end
`else
      if (src_a != RNONE) val_a = regs_q[src_a];
      if (src_b != RNONE) val_b = regs_q[src_b];
`endif
   end

   // Next register state: M write applied after E so it wins on a shared ID
   always_comb begin
      regs_d = regs_q;
      if (dst_e != RNONE) regs_d[dst_e] = bus.valE;
      if (dst_m != RNONE) regs_d[dst_m] = bus.valM;
   end

   // Register file update with synchronous clear
   always_ff @(posedge clk) begin
      if (!rst_n) regs_q <= '{default: '0};
      else        regs_q <= regs_d;
   end

   assign bus.srcA = src_a;
   assign bus.srcB = src_b;
   assign bus.dstE = dst_e;
   assign bus.dstM = dst_m;
   assign bus.valA = val_a;
   assign bus.valB = val_b;
endmodule

// File: tb/tb_y86_decode_regfile.sv
// Self-checking bench for y86_decode_regfile: instruction-table reference
// model checked every cycle, plus literal expectations from worked examples.
module tb_y86_decode_regfile;
   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   logic [63:0] mreg [15];

   y86_decode_regfile_if #(.W(64)) bus ();

   y86_decode_regfile #(.W(64), .NREG(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference decode written as the instruction table's membership rules
   function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB})             return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      if (ic == 4'h2)                         return c ? rb : 4'hF;
      if (ic inside {4'h3, 4'h6})             return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [63:0] m_read(input logic [3:0] id, input logic [3:0] de,
                                          input logic [3:0] dm, input logic [63:0] ve,
                                          input logic [63:0] vm);
      if (id == 4'hF) return 64'h0;
`ifdef REGFILE_BYPASS_EN
      if (id == dm) return vm;
      if (id == de) return ve;
`endif
      return mreg[id];
   endfunction

   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm,
                        input logic rn);
      bus.icode = ic;
      bus.rA    = ra;
      bus.rB    = rb;
      bus.cnd   = c;
      bus.valE  = ve;
      bus.valM  = vm;
      rst_n     = rn;
      #1;
   endtask

   // Compare all outputs against the model mid-cycle, then advance the model at the edge
   task automatic tick();
      logic [3:0] ea, eb, ee, em;
      @(negedge clk);
      ea = m_srcA(bus.icode, bus.rA);
      eb = m_srcB(bus.icode, bus.rB);
      ee = m_dstE(bus.icode, bus.rB, bus.cnd);
      em = m_dstM(bus.icode, bus.rA);
      chk("srcA", {60'h0, bus.srcA}, {60'h0, ea});
      chk("srcB", {60'h0, bus.srcB}, {60'h0, eb});
      chk("dstE", {60'h0, bus.dstE}, {60'h0, ee});
      chk("dstM", {60'h0, bus.dstM}, {60'h0, em});
      chk("valA", bus.valA, m_read(ea, ee, em, bus.valE, bus.valM));
      chk("valB", bus.valB, m_read(eb, ee, em, bus.valE, bus.valM));
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) mreg[i] = 64'h0;
      end else begin
         if (ee != 4'hF) mreg[ee] = bus.valE;
         if (em != 4'hF) mreg[em] = bus.valM;
      end
      #1;
   endtask

   // Read register id through rmmovq (reads rA/rB, writes nothing)
   task automatic rd(input logic [3:0] id, input logic [63:0] exp, input string name);
      drive(4'h4, id, id, 1'b0, 64'h0, 64'h0, 1'b1);
      chk(name, bus.valA, exp);
      tick();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) mreg[i] = 64'h0;

      // reset state: every register reads zero
      for (int i = 0; i < 15; i++) rd(4'(i), 64'h0, "reset_reg");

      // irmovq $0x420, %rcx
      drive(4'h3, 4'hF, 4'h1, 1'b0, 64'h420, 64'h0, 1'b1);
      chk("irmov_srcA", {60'h0, bus.srcA}, 64'hF);
      chk("irmov_srcB", {60'h0, bus.srcB}, 64'hF);
      chk("irmov_dstM", {60'h0, bus.dstM}, 64'hF);
      chk("irmov_dstE", {60'h0, bus.dstE}, 64'h1);
      tick();
      rd(4'h1, 64'h420, "irmov_R1");

      // irmovq $0x20, %rsp then ret
      drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h20, 64'h0, 1'b1);
      tick();
      drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h28, 64'h0, 1'b1);
      chk("ret_srcA", {60'h0, bus.srcA}, 64'h4);
      chk("ret_srcB", {60'h0, bus.srcB}, 64'h4);
      chk("ret_dstE", {60'h0, bus.dstE}, 64'h4);
`ifndef REGFILE_BYPASS_EN
      chk("ret_valA", bus.valA, 64'h20);
      chk("ret_valB", bus.valB, 64'h20);
`endif
      tick();
      rd(4'h4, 64'h28, "ret_R4");

      // cmovq taken
      drive(4'h2, 4'h1, 4'h7, 1'b1, 64'h420, 64'h0, 1'b1);
      chk("cmov1_srcA", {60'h0, bus.srcA}, 64'h1);
      chk("cmov1_valA", bus.valA, 64'h420);
      chk("cmov1_dstE", {60'h0, bus.dstE}, 64'h7);
      tick();
      rd(4'h7, 64'h420, "cmov1_R7");

      // cmovq not taken
      drive(4'h2, 4'h7, 4'h6, 1'b0, 64'h999, 64'h0, 1'b1);
      chk("cmov0_srcA", {60'h0, bus.srcA}, 64'h7);
      chk("cmov0_valA", bus.valA, 64'h420);
      chk("cmov0_dstE", {60'h0, bus.dstE}, 64'hF);
      tick();
      rd(4'h6, 64'h0, "cmov0_R6");

      // popq %rsp: valM wins over valE
      drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h30, 64'h99, 1'b1);
      chk("pop_dstE", {60'h0, bus.dstE}, 64'h4);
      chk("pop_dstM", {60'h0, bus.dstM}, 64'h4);
      tick();
      rd(4'h4, 64'h99, "pop_R4");

      // OPq writing and reading %rdx in the same cycle
      drive(4'h6, 4'h2, 4'h2, 1'b0, 64'hAB, 64'h0, 1'b1);
`ifdef REGFILE_BYPASS_EN
      chk("raw_valA", bus.valA, 64'hAB);
`else
      chk("raw_valA", bus.valA, 64'h0);
`endif
      tick();
      rd(4'h2, 64'hAB, "raw_R2");

      // every icode with both cnd values
      for (int ic = 0; ic < 16; ic++) begin
         for (int c = 0; c < 2; c++) begin
            drive(4'(ic), 4'(2 + c), 4'(5 + ic % 7), 1'(c),
                  {32'h0, $urandom}, {32'h1, $urandom}, 1'b1);
            tick();
         end
      end
      for (int i = 0; i < 15; i++) rd(4'(i), mreg[i], "sweep_reg");

      // reset discards the pending write and clears everything
      drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h55, 64'h0, 1'b1);
      tick();
      rd(4'h3, 64'h55, "pre_rst_R3");
      drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h77, 64'h0, 1'b0);
      chk("rst_dstE", {60'h0, bus.dstE}, 64'h3);
      tick();
      for (int i = 0; i < 15; i++) rd(4'(i), 64'h0, "post_rst_reg");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
